// File: rtl/fetch_unit.sv
// fetch_unit: PC generation, single-outstanding instruction memory requests
// and a small FIFO queue feeding decode.
//
// Parameters:
//   XLEN     address / instruction width
//   RESET_PC PC loaded by reset
//   PC_INC   sequential PC increment
//   DEPTH    fetch queue entries (power of two, >= 2)
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   redirect_valid / redirect_pc    trap/flush redirect (highest priority)
//   b_taken / b_pc                  taken-branch redirect
//   imem_req_valid/ready/addr       request channel (addr = current PC)
//   imem_rsp_valid / imem_rsp_data  in-order response channel
//   out_valid/ready, out_pc/instr   queue head towards decode
//   perf_redirects, perf_stalls     saturating counters (FETCH_PERF_EN only)
// Optional feature macro: FETCH_PERF_EN.
module fetch_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              PC_INC   = 4,
    parameter int              DEPTH    = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            b_taken,
    input  logic [XLEN-1:0] b_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
`ifdef FETCH_PERF_EN
    output logic [XLEN-1:0] out_instr,
    output logic [31:0]     perf_redirects,
    output logic [31:0]     perf_stalls
`else
    output logic [XLEN-1:0] out_instr
`endif
);

    localparam int              AW  = $clog2(DEPTH);
    localparam logic [XLEN-1:0] INC = XLEN'(PC_INC);

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] req_pc;
    logic            outstanding;
    logic            drop;

    logic [XLEN-1:0] q_pc    [DEPTH];
    logic [XLEN-1:0] q_instr [DEPTH];
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic [AW:0]     count;
    logic [AW-1:0]   head;

    logic            redirect;
    logic [XLEN-1:0] target;
    logic            full;
    logic            accept;
    logic            rsp_hit;
    logic            push;
    logic            pop;

    assign redirect = redirect_valid || b_taken;
    assign target   = redirect_valid ? redirect_pc : b_pc;

    // count never exceeds DEPTH, so its MSB alone flags a full queue
    assign full = count[AW];

    // rst_n gates the request so nothing is offered while in reset
    assign imem_req_valid = rst_n && !outstanding && !full && !redirect;
    assign imem_req_addr  = pc;
    assign accept         = imem_req_valid && imem_req_ready;

    // responses without an outstanding request are stray and ignored
    assign rsp_hit = imem_rsp_valid && outstanding;
    assign push    = rsp_hit && !drop && !redirect;

    assign out_valid = (count != '0);
    assign pop       = out_valid && out_ready && !redirect;

    // When empty, show the entry just before rd_ptr so the outputs keep
    // the last head rather than a stale slot.
    assign head      = out_valid ? rd_ptr : rd_ptr - 1'b1;
    assign out_pc    = q_pc[head];
    assign out_instr = q_instr[head];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= RESET_PC;
            req_pc      <= '0;
            outstanding <= 1'b0;
            drop        <= 1'b0;
        end else if (redirect) begin
            pc <= target;
            if (rsp_hit) begin
                outstanding <= 1'b0;
                drop        <= 1'b0;
            end else if (outstanding) begin
                drop <= 1'b1;
            end
        end else begin
            if (accept) begin
                pc          <= pc + INC;
                req_pc      <= pc;
                outstanding <= 1'b1;
            end
            if (rsp_hit) begin
                outstanding <= 1'b0;
                drop        <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (redirect) begin
            // flush: advance past the old head so it stays visible
            rd_ptr <= rd_ptr + 1'b1;
            wr_ptr <= rd_ptr + 1'b1;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case (1'b1)
                push && !pop: count <= count + 1'b1;
                pop && !push: count <= count - 1'b1;
                default:      count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_pc[wr_ptr]    <= req_pc;
            q_instr[wr_ptr] <= imem_rsp_data;
        end
    end

`ifdef FETCH_PERF_EN
    logic stall;

    assign stall = imem_req_valid && !imem_req_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_redirects <= '0;
            perf_stalls    <= '0;
        end else begin
            if (redirect && (perf_redirects != '1)) begin
                perf_redirects <= perf_redirects + 1'b1;
            end
            if (stall && (perf_stalls != '1)) begin
                perf_stalls <= perf_stalls + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed and random stimulus for fetch_unit, checked
// against a transaction-level model of the fetch stream.
module tb_fetch_unit;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        b_taken;
    logic [31:0] b_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_redirects;
    logic [31:0] perf_stalls;
`endif

    fetch_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .b_taken        (b_taken),
        .b_pc           (b_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
`ifdef FETCH_PERF_EN
        .out_instr      (out_instr),
        .perf_redirects (perf_redirects),
        .perf_stalls    (perf_stalls)
`else
        .out_instr      (out_instr)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // reference model: expected decode stream and fetch state
    logic [63:0] exp_q [$];
    logic [31:0] popped [$];
    logic [31:0] acc_q [$];
    logic [31:0] m_pc;
    logic        m_out;
    logic        m_drop;

    // memory model
    logic        mem_busy;
    logic [31:0] mem_addr;
    int          mem_dly;
    int          lat;

    function automatic logic [31:0] ifn(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic rv, input logic [31:0] rpc,
                        input logic bt, input logic [31:0] bpc,
                        input logic rdy, input logic ordy,
                        input logic stray);
        logic        rsp;
        logic        exp_req;
        logic        redir;
        logic        acc;
        logic [63:0] hd;
        rsp            = mem_busy && (mem_dly == 0);
        redirect_valid = rv;
        redirect_pc    = rpc;
        b_taken        = bt;
        b_pc           = bpc;
        imem_rsp_valid = rsp || (!mem_busy && stray);
        imem_rsp_data  = rsp ? ifn(mem_addr) : $urandom;
        imem_req_ready = mem_busy ? 1'b0 : rdy;
        out_ready      = ordy;
        #1;
        exp_req = !m_out && (exp_q.size() < DEPTH) && !rv && !bt;
        chk("req_valid", {63'd0, imem_req_valid}, {63'd0, exp_req});
        if (exp_req) begin
            chk("req_addr", {32'd0, imem_req_addr}, {32'd0, m_pc});
        end
        chk("out_valid", {63'd0, out_valid}, {63'd0, exp_q.size() != 0});
        if (exp_q.size() != 0) begin
            hd = exp_q[0];
            chk("out_pc_instr", {out_pc, out_instr}, hd);
        end
        redir = rv || bt;
        acc   = exp_req && imem_req_ready;
        if (exp_q.size() != 0 && ordy && !redir) begin
            hd = exp_q.pop_front();
            popped.push_back(hd[63:32]);
        end
        if (rsp) begin
            if (m_out) begin
                if (!redir && !m_drop) begin
                    exp_q.push_back({mem_addr, ifn(mem_addr)});
                end
                m_out  = 1'b0;
                m_drop = 1'b0;
            end
            mem_busy = 1'b0;
        end else if (mem_busy) begin
            mem_dly--;
        end
        if (redir) begin
            exp_q.delete();
            m_pc = rv ? rpc : bpc;
            if (m_out) begin
                m_drop = 1'b1;
            end
        end
        if (acc) begin
            acc_q.push_back(m_pc);
            m_out    = 1'b1;
            mem_busy = 1'b1;
            mem_addr = m_pc;
            mem_dly  = (lat < 0) ? int'($urandom_range(3)) : lat;
            m_pc     = m_pc + 32'd4;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n, input logic ordy);
        for (int i = 0; i < n; i++) begin
            step(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, ordy, 1'b0);
        end
    endtask

    initial begin
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        b_taken        = 1'b0;
        b_pc           = '0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        out_ready      = 1'b0;
        m_pc           = RESET_PC;
        m_out          = 1'b0;
        m_drop         = 1'b0;
        mem_busy       = 1'b0;
        mem_addr       = '0;
        mem_dly        = 0;
        lat            = 0;

        // reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_req_valid", {63'd0, imem_req_valid}, 64'd0);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_req_addr", {32'd0, imem_req_addr}, {32'd0, RESET_PC});
        rst_n = 1'b1;

        // sequential fetch, response one cycle after each request
        popped.delete();
        idle(12, 1'b1);
        chk("seq_pc0", {32'd0, popped[0]}, 64'h0);
        chk("seq_pc1", {32'd0, popped[1]}, 64'h4);
        chk("seq_pc2", {32'd0, popped[2]}, 64'h8);
        chk("seq_pc3", {32'd0, popped[3]}, 64'hC);

        // fill the queue with decode stalled, then drain
        idle(20, 1'b0);
        chk("full_no_req", {63'd0, imem_req_valid}, 64'd0);
        chk("full_valid", {63'd0, out_valid}, 64'd1);
        idle(20, 1'b1);

        // taken branch while the request to 0x8 is outstanding
        step(1'b1, 32'h8, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        lat = 2;
        acc_q.delete();
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        chk("br_first_req", {32'd0, acc_q[0]}, 64'h8);
        step(1'b0, 32'h0, 1'b1, 32'h100, 1'b1, 1'b1, 1'b0);
        acc_q.delete();
        lat = 0;
        idle(8, 1'b1);
        chk("br_next_req", {32'd0, acc_q[0]}, 64'h100);

        // trap redirect wins over branch
        step(1'b1, 32'h200, 1'b1, 32'h100, 1'b1, 1'b1, 1'b0);
        acc_q.delete();
        idle(6, 1'b1);
        chk("prio_req", {32'd0, acc_q[0]}, 64'h200);

        // PC wrap-around
        step(1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        acc_q.delete();
        idle(8, 1'b1);
        chk("wrap_req0", {32'd0, acc_q[0]}, 64'hFFFF_FFFC);
        chk("wrap_req1", {32'd0, acc_q[1]}, 64'h0);

        // reset mid-request with two entries queued
        step(1'b1, 32'h40, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        lat = 1;
        for (int k = 0; k < 20 && !(exp_q.size() == 2 && m_out); k++) begin
            step(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        end
        chk("pre_rst_valid", {63'd0, out_valid}, 64'd1);
        chk("pre_rst_pc", {32'd0, out_pc}, 64'h40);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("mid_rst_req_valid", {63'd0, imem_req_valid}, 64'd0);
        chk("mid_rst_pc", {32'd0, imem_req_addr}, {32'd0, RESET_PC});
        exp_q.delete();
        m_pc   = RESET_PC;
        m_out  = 1'b0;
        m_drop = 1'b0;
        acc_q.delete();
        @(negedge clk);
        chk("hold_rst_out_valid", {63'd0, out_valid}, 64'd0);
        rst_n = 1'b1;
        lat   = 0;
        idle(8, 1'b1);
        chk("post_rst_req", {32'd0, acc_q[0]}, {32'd0, RESET_PC});

        // random traffic
        lat = -1;
        for (int i = 0; i < 3000; i++) begin
            logic        rv;
            logic        bt;
            logic [31:0] rp;
            logic [31:0] bp;
            rv = ($urandom_range(99) < 5);
            bt = ($urandom_range(99) < 8);
            rp = ($urandom_range(9) == 0) ? 32'hFFFF_FFF8
                                          : ($urandom & 32'h0000_FFFC);
            bp = $urandom & 32'h0000_FFFC;
            step(rv, rp, bt, bp, $urandom_range(99) < 70,
                 $urandom_range(99) < 60, $urandom_range(9) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
